// File: rtl/ddr_req_arbiter_if.sv
// Request/command bundle between the requesters, the DDR command channel and ddr_req_arbiter.
// Handshake: cmd_valid holds cmd_type/cmd_addr/cmd_len stable until the cycle cmd_ready is sampled high;
// a burst is closed by a one-cycle burst_done and answered by a one-cycle done bit for the owner.
interface ddr_req_arbiter_if #(
  parameter int DDR_ADDR_WIDTH = 28
);
  logic                      ddr_rdy;
  logic                      st_req;
  logic [DDR_ADDR_WIDTH-1:0] st_addr;
  logic                      rd_req;
  logic [DDR_ADDR_WIDTH-1:0] rd_addr;
  logic                      jmp_req;
  logic [DDR_ADDR_WIDTH-1:0] jmp_addr;
  logic                      ins_req;
  logic [DDR_ADDR_WIDTH-1:0] ins_addr;
  logic [7:0]                ins_len;
  logic [3:0]                gnt;
  logic [3:0]                done;
  logic                      cmd_valid;
  logic [1:0]                cmd_type;
  logic [DDR_ADDR_WIDTH-1:0] cmd_addr;
  logic [9:0]                cmd_len;
  logic                      cmd_ready;
  logic                      burst_done;
  logic                      timeout_err;

  modport master (
    output ddr_rdy, st_req, st_addr, rd_req, rd_addr, jmp_req, jmp_addr,
           ins_req, ins_addr, ins_len, cmd_ready, burst_done,
    input  gnt, done, cmd_valid, cmd_type, cmd_addr, cmd_len, timeout_err
  );

  modport slave (
    input  ddr_rdy, st_req, st_addr, rd_req, rd_addr, jmp_req, jmp_addr,
           ins_req, ins_addr, ins_len, cmd_ready, burst_done,
    output gnt, done, cmd_valid, cmd_type, cmd_addr, cmd_len, timeout_err
  );
endinterface

// File: rtl/ddr_req_arbiter.sv
// Fixed-priority (st > rd > jmp > ins) arbiter issuing one DDR burst at a time.
// Optional instruction-fetch starvation guard enabled by defining DDR_ARB_AGING_EN.
module ddr_req_arbiter #(
  parameter int DDR_ADDR_WIDTH   = 28,
  parameter int DATA_CACHE_DEPTH = 16,
  parameter int TIMEOUT_CYCLES   = 1023,
  parameter int AGE_LIMIT        = 64
) (
  input  logic             mem_clk,
  input  logic             rst,
  ddr_req_arbiter_if.slave bus,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 10-bit watchdog");
  end
  if (AGE_LIMIT < 1 || AGE_LIMIT > 255) begin : g_bad_age
    $error("AGE_LIMIT must fit the 8-bit age counter");
  end

  state_t                    state_q, state_d;
  logic [3:0]                gnt_q, gnt_d;
  logic [3:0]                done_q, done_d;
  logic [1:0]                type_q, type_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [9:0]                len_q, len_d;
  logic [9:0]                wd_q, wd_d;
  logic                      tmo_q, tmo_d;
  logic [3:0]                sel;
  logic                      any_req;
  logic                      ins_boost;

  assign any_req = bus.st_req | bus.rd_req | bus.jmp_req | bus.ins_req;

`ifdef DDR_ARB_AGING_EN
  logic [7:0] age_q, age_d;

  assign ins_boost = bus.ins_req && (age_q >= 8'(AGE_LIMIT));

  // Age counts IDLE arbitrations that ins lost while it was requesting.
  always_comb begin
    age_d = age_q;
    if (!bus.ins_req) begin
      age_d = '0;
    end else if (state_q == S_IDLE && bus.ddr_rdy) begin
      age_d = sel[0] ? 8'd0 : age_q + 8'd1;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
`else
  assign ins_boost = 1'b0;
`endif

  always_comb begin
    sel = 4'b0000;
    if (ins_boost)        sel = 4'b0001;
    else if (bus.st_req)  sel = 4'b1000;
    else if (bus.rd_req)  sel = 4'b0100;
    else if (bus.jmp_req) sel = 4'b0010;
    else if (bus.ins_req) sel = 4'b0001;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    type_d  = type_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ddr_rdy && any_req) begin
          gnt_d   = sel;
          state_d = S_ISSUE;
          case (sel)
            4'b1000: begin type_d = 2'd3; addr_d = bus.st_addr;  len_d = 10'(DATA_CACHE_DEPTH);     end
            4'b0100: begin type_d = 2'd1; addr_d = bus.rd_addr;  len_d = 10'(DATA_CACHE_DEPTH + 1); end
            4'b0010: begin type_d = 2'd2; addr_d = bus.jmp_addr; len_d = 10'd1;                     end
            default: begin type_d = 2'd0; addr_d = bus.ins_addr; len_d = {2'b00, bus.ins_len};      end
          endcase
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready) begin
          state_d = S_WAIT;
          wd_d    = '0;
        end
      end
      S_WAIT: begin
        // A real burst_done wins over a watchdog expiry in the same cycle.
        if (bus.burst_done || wd_q == 10'(TIMEOUT_CYCLES - 1)) begin
          if (!bus.burst_done) tmo_d = 1'b1;
          state_d = S_RELEASE;
          done_d  = gnt_q;
          gnt_d   = '0;
        end else begin
          wd_d = wd_q + 10'd1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.cmd_valid   = (state_q == S_ISSUE);
  assign bus.cmd_type    = type_q;
  assign bus.cmd_addr    = addr_q;
  assign bus.cmd_len     = len_q;
  assign bus.timeout_err = tmo_q;
  assign state_o         = state_q;

endmodule
